// File: rtl/seq_signed_divider.sv
// seq_signed_divider
//   Sequential signed divider: 2W-bit signed dividend / W-bit signed divisor.
//   Restoring division on magnitudes, one quotient bit per cycle, then a
//   single sign-fixup/range-check cycle. Quotient truncates toward zero and
//   the remainder carries the sign of the dividend.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only when idle
//   dividend     2W-bit signed dividend
//   divisor      W-bit signed divisor
//   busy         operation in progress
//   done         one-cycle pulse when results are valid
//   quotient     W-bit signed quotient
//   remainder    W-bit signed remainder
//   overflow     quotient does not fit W signed bits
//   div_by_zero  divisor was zero
//
// state  | meaning
// IDLE   | waiting for start; divide-by-zero answered here in one cycle
// ITER   | one restoring-division step per cycle, 2W cycles
// FIX    | range check and sign fixup, raise done
module seq_signed_divider #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*W);
  localparam logic [CW-1:0] LAST_STEP = CW'(2*W-1);
  // Largest quotient magnitudes representable for positive / negative results.
  localparam logic [2*W-1:0] LIM_POS = (2*W)'((2**(W-1)) - 1);
  localparam logic [2*W-1:0] LIM_NEG = (2*W)'(2**(W-1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]     state;
  logic           sign_q;
  logic           sign_r;
  // Holds the dividend magnitude at first; quotient bits shift in from the
  // bottom as the dividend bits shift out the top.
  logic [2*W-1:0] qbits;
  logic [W-1:0]   dvs_mag;
  logic [W:0]     prem;
  logic [CW-1:0]  count;

  logic [2*W-1:0] dvd_abs;
  logic [W-1:0]   dvs_abs;
  logic [W:0]     shifted;
  logic [W+1:0]   trial;
  logic           trial_ok;
  logic           range_ovf;
  logic [W-1:0]   q_fixed;
  logic [W-1:0]   r_fixed;

  // Unsigned magnitudes: the most negative value maps onto its own bit
  // pattern, which is the correct unsigned magnitude.
  assign dvd_abs = dividend[2*W-1] ? -dividend : dividend;
  assign dvs_abs = divisor[W-1]    ? -divisor  : divisor;

  assign shifted  = {prem[W-1:0], qbits[2*W-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_mag};
  assign trial_ok = ~trial[W+1];

  assign range_ovf = sign_q ? (qbits > LIM_NEG) : (qbits > LIM_POS);
  assign q_fixed   = sign_q ? -qbits[W-1:0] : qbits[W-1:0];
  assign r_fixed   = sign_r ? -prem[W-1:0]  : prem[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      qbits       <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            if (divisor == '0) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
            end else begin
              div_by_zero <= 1'b0;
              sign_q      <= dividend[2*W-1] ^ divisor[W-1];
              sign_r      <= dividend[2*W-1];
              qbits       <= dvd_abs;
              dvs_mag     <= dvs_abs;
              prem        <= '0;
              count       <= '0;
              busy        <= 1'b1;
              state       <= S_ITER;
            end
          end
        end
        S_ITER: begin
          prem  <= trial_ok ? trial[W:0] : shifted;
          qbits <= {qbits[2*W-2:0], trial_ok};
          count <= count + CW'(1);
          if (count == LAST_STEP) state <= S_FIX;
        end
        S_FIX: begin
          if (range_ovf) begin
            overflow  <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            overflow  <= 1'b0;
            quotient  <= q_fixed;
            remainder <= r_fixed;
          end
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, overflow, div_by_zero;
  logic [3:0] quotient, remainder;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       ovf;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  seq_signed_divider #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: integer division truncating toward zero, remainder with the
  // sign of the dividend, overflow when the quotient leaves [-8, 7].
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    int ai, bi, q, r;
    ai = $signed(a);
    bi = $signed(b);
    e = '0;
    if (bi == 0) begin
      e.dbz = 1'b1;
    end else begin
      q = ai / bi;
      r = ai % bi;
      if (q > 7 || q < -8) e.ovf = 1'b1;
      else begin
        e.q = q[3:0];
        e.r = r[3:0];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 with no outstanding request, required none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("overflow", overflow, e.ovf);
        chk("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  // Called right after a negedge; returns at the negedge where done is seen
  // (chain=1) or one cycle later after checking that done dropped.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       input bit pokes, input bit chain);
    int n, busy_n;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    n = 1;
    busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      n++;
      start = pokes && (n == 3 || n == 9);
    end
    chk("done_latency", n, (b == 0) ? 1 : 10);
    chk("busy_cycles", busy_n, (b == 0) ? 0 : 9);
    chk("busy_at_done", busy, 0);
    if (!chain) begin
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    logic [3:0] x, y;
    int p;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'd20, 4'd3, 0, 0);
    do_op(-8'sd20, 4'd3, 0, 0);
    do_op(8'd20, -4'sd3, 0, 0);
    do_op(-8'sd20, -4'sd3, 0, 0);
    do_op(-8'sd56, 4'd7, 0, 0);
    do_op(8'd56, 4'd7, 0, 0);
    do_op(8'd64, 4'd3, 0, 0);
    do_op(8'h80, 4'h8, 0, 0);
    do_op(8'd5, 4'd0, 0, 0);

    // Ignored starts mid-operation and during FIX, then back-to-back issue.
    do_op(8'd20, 4'd3, 1, 1);
    do_op(8'd7, 4'd2, 0, 0);
    repeat (3) @(negedge clk);
    chk("hold_q", quotient, 4'd3);
    chk("hold_r", remainder, 4'd1);
    chk("hold_done", done, 0);

    // Reset between edges in the middle of an operation.
    dividend = 8'd20;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_dbz", div_by_zero, 0);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_op(8'd20, 4'd3, 0, 0);

    repeat (40) begin
      do_op(8'($urandom), 4'($urandom_range(1, 15)), 0, 0);
    end

    // A product fed back against one of its factors must return the other.
    repeat (20) begin
      x = 4'($urandom);
      y = 4'($urandom_range(1, 15));
      p = $signed(x) * $signed(y);
      do_op(p[7:0], y, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
Sequential signed divider that performs the inverse of the team's 4x4 signed Booth multiplier. It divides a 2W-bit signed dividend (a product-width value) by a W-bit signed divisor, using restoring division on magnitudes with sign fixup. It returns a W-bit quotient and W-bit remainder under a start/busy/done handshake. It sits beside the multiplier in the arithmetic datapath, so a multiply result can be fed back for checking or for inverse operations.

Parameters:
W, 4, operand width; dividend is 2W bits; quotient and remainder are W bits each.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  2W  signed dividend (two's complement)
divisor  input  W  signed divisor (two's complement)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results become valid
quotient  output  W  signed quotient, truncated toward zero
remainder  output  W  signed remainder; takes the sign of the dividend, or is 0
overflow  output  1  quotient not representable in W signed bits
div_by_zero  output  1  divisor was 0

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous, active-low.
  - On rst_n=0: state=IDLE; busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0; all internal registers cleared.
  - Reset mid-operation aborts the operation immediately; no done pulse follows.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1, divisor!=0: on this edge, latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - On the same edge, latch the 2W-bit |dividend| and W-bit |divisor| as unsigned magnitudes (no overflow, since the magnitude of the most negative value fits unsigned).
  - Then clear the partial remainder (W+1 bits), set count=0, busy=1, go to ITER.
  - start=1, divisor==0: on the same edge, done=1, div_by_zero=1, overflow=0, quotient=0, remainder=0; stay in IDLE; busy stays 0.
- ITER, one quotient bit per cycle, 2W cycles:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract |divisor| from the partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - count increments each cycle; after the cycle with count==2W-1, go to FIX.
- FIX, one cycle:
  - Qm = 2W-bit quotient magnitude; Rm = remainder magnitude.
  - Range check: overflow if (sign_q=0 and Qm > 2^(W-1)-1) or (sign_q=1 and Qm > 2^(W-1)).
  - If overflow: overflow=1, quotient=0, remainder=0.
  - Otherwise: quotient = sign_q ? -Qm : Qm (low W bits); remainder = sign_r ? -Rm : Rm (low W bits).
  - div_by_zero=0, done=1, busy=0, go to IDLE.
- Latency:
  - start accepted at edge T; done is high for exactly the cycle after edge T+2W+1, i.e. 2W+1 cycles (9 for W=4).
  - Divide-by-zero: done is high after edge T, i.e. 1 cycle.
- Handshake and output holding:
  - done is a single-cycle pulse and drops to 0 on the next edge.
  - quotient, remainder, overflow and div_by_zero hold their values until the next accepted start.
  - On an accepted start, overflow and div_by_zero clear (except in the divide-by-zero case, where div_by_zero is set).
- Boundary conditions:
  - start while busy=1 is ignored; inputs do not need to be held after the accept edge.
  - start in the same cycle as a FIX completion is ignored, because the state is not IDLE on that edge.
  - Back-to-back: start may be accepted on the edge immediately after the done pulse begins (IDLE).
  - Remainder magnitude is always < |divisor| <= 2^(W-1), so it always fits W signed bits.
  - Quotient −2^(W-1) (e.g. 4'h8) is legal when sign_q=1.

Test Plan:
- W=4, dividend=8'sd20, divisor=4'sd3 -> after 9 cycles done=1, quotient=4'sd6, remainder=4'sd2, overflow=0, div_by_zero=0, busy high for exactly 9 cycles.
- Sign combinations: -20/3 -> q=4'hA (-6), r=4'hE (-2); 20/-3 -> q=-6, r=2; -20/-3 -> q=6, r=-2.
- Boundary: -56/7 -> q=4'h8 (-8), r=0, overflow=0; 56/7 -> overflow=1, q=0, r=0; 64/3 -> overflow=1; 8'h80 (-128)/4'h8 (-8) -> overflow=1 (Qm=16).
- Divide by zero: dividend=5, divisor=0, start -> done=1 on the next cycle, div_by_zero=1, q=0, r=0, busy never asserted.
- Handshake: pulse start again at cycles 3 and 9 after the accepted start of 20/3 -> both ignored, single done, results unchanged; start on the cycle after done with 7/2 -> q=3, r=1.
- Reset mid-op: deassert rst_n asynchronously (between edges) at cycle 5 of an operation -> all outputs 0 immediately, no done pulse; the next start operates normally.
- Randomized cross-check: random 8-bit dividend and nonzero 4-bit divisor -> results match the truncating-division model for in-range cases and overflow=1 otherwise; a multiplier product divided by its factor returns the other factor with r=0.
